enigma_rotor: RTL and testbench

- One stepping rotor stage of the Enigma datapath. It sits directly upstream of the reflector and sits in the rotor chain.
- Forward path (dec=0): an ASCII letter travels toward the reflector and is enciphered through the rotor wiring at the current rotor offset.
- Backward path (dec=1): the reflector's output returns through the inverse wiring, found by a sequential table scan.
- The rotor keeps its own offset counter, steps on request, and emits a notch carry for the next rotor.

---
 rtl/enigma_rotor.sv | 177 +++++++++++++++++
 tb/tb_enigma_rotor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor.sv
`default_nettype none
// ============================================================================
// Module      : enigma_rotor
// Description : One stepping rotor stage of the Enigma datapath, located
//               directly upstream of the reflector.
//               Forward (dec=0): letter enciphered through the wiring table
//               at the current offset, optionally stepping the rotor first.
//               Backward (dec=1): inverse wiring found by scanning the table
//               one entry per cycle.
//               Emits a one-cycle notch carry for the next rotor.
// Ports       : clk, reset_n (sync, active-low)
//               set, idx_in[207:0], offset_in[4:0]  - table / offset load
//               valid, din[7:0], dec, step          - transaction request
//               dout[7:0], done, err                - registered result
//               busy, carry_out, offset_out[4:0]    - status
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_rotor #(
  parameter int NOTCH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         set,
  input  logic [207:0] idx_in,
  input  logic [4:0]   offset_in,
  input  logic         valid,
  input  logic [7:0]   din,
  input  logic         dec,
  input  logic         step,
  output logic [7:0]   dout,
  output logic         done,
  output logic         err,
  output logic         busy,
  output logic         carry_out,
  output logic [4:0]   offset_out
);

  localparam logic [7:0] C_ASCII_A = 8'h41;
  localparam logic [7:0] C_ASCII_Z = 8'h5A;
  localparam logic [7:0] C_QMARK   = 8'h3F;
  localparam logic [4:0] C_NOTCH   = 5'(NOTCH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] table_q [26];
  logic [4:0] offset_q;
  logic [4:0] d_q;       // latched forward letter index
  logic [4:0] target_q;  // backward search value
  logic [4:0] j_q;       // backward scan position
  logic [7:0] dout_q;
  logic       done_q;
  logic       err_q;
  logic       carry_q;

  // Reduce a value in 0..51 to 0..25.
  function automatic logic [4:0] mod26_small(input logic [5:0] v);
    logic [5:0] r;
    r = (v >= 6'd26) ? (v - 6'd26) : v;
    return r[4:0];
  endfunction

  // Full reduction; table entries are not guaranteed to be letters.
  function automatic logic [4:0] mod26_full(input logic [8:0] v);
    logic [8:0] r;
    r = v % 9'd26;
    return r[4:0];
  endfunction

  logic       w_din_ok;
  logic [7:0] w_d;
  logic [4:0] w_target;
  logic [4:0] offset_d;   // offset after a step
  logic [4:0] w_fidx;
  logic [7:0] w_fval;
  logic [4:0] w_fout;
  logic [7:0] w_sval;
  logic       w_scan_hit;
  logic [4:0] w_sout;

  assign w_din_ok = (din >= C_ASCII_A) && (din <= C_ASCII_Z);
  assign w_d      = din - C_ASCII_A;
  assign w_target = mod26_small({1'b0, w_d[4:0]} + {1'b0, offset_q});
  assign offset_d = (offset_q == 5'd25) ? 5'd0 : (offset_q + 5'd1);

  // Forward path uses offset_q, which already holds the stepped value in FWD.
  assign w_fidx = mod26_small({1'b0, d_q} + {1'b0, offset_q});
  assign w_fval = table_q[w_fidx] - C_ASCII_A;
  assign w_fout = mod26_full({1'b0, w_fval} + 9'd26 - {4'd0, offset_q});

  assign w_sval     = table_q[j_q] - C_ASCII_A;
  assign w_scan_hit = (w_sval == {3'd0, target_q});
  assign w_sout     = mod26_small({1'b0, j_q} + 6'd26 - {1'b0, offset_q});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      offset_q <= 5'd0;
      d_q      <= 5'd0;
      target_q <= 5'd0;
      j_q      <= 5'd0;
      dout_q   <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      carry_q  <= 1'b0;
      for (int i = 0; i < 26; i++) begin
        table_q[i] <= C_ASCII_A + 8'(i);
      end
    end else begin
      // Strobes default low; dout holds.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (set) begin
            for (int i = 0; i < 26; i++) begin
              table_q[i] <= idx_in[207-8*i -: 8];
            end
            offset_q <= (offset_in > 5'd25) ? 5'd0 : offset_in;
          end else if (valid) begin
            if (!w_din_ok) begin
              dout_q <= C_QMARK;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (!dec) begin
              d_q <= w_d[4:0];
              if (step) begin
                offset_q <= offset_d;
                carry_q  <= (offset_q == C_NOTCH);
              end
              state_q <= FWD;
            end else begin
              target_q <= w_target;
              j_q      <= 5'd0;
              state_q  <= SCAN;
            end
          end
        end
        FWD: begin
          dout_q  <= {3'd0, w_fout} + C_ASCII_A;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        SCAN: begin
          if (w_scan_hit) begin
            dout_q  <= {3'd0, w_sout} + C_ASCII_A;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (j_q == 5'd25) begin
            // Table is not a permutation: no inverse exists.
            dout_q  <= C_QMARK;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            j_q <= j_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign carry_out  = carry_q;
  assign offset_out = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_enigma_rotor.sv
`default_nettype none
// ============================================================================
// Module      : tb_enigma_rotor
// Description : Directed self-checking bench for enigma_rotor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enigma_rotor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         set;
  logic [207:0] idx_in;
  logic [4:0]   offset_in;
  logic         valid;
  logic [7:0]   din;
  logic         dec;
  logic         step;
  logic [7:0]   dout;
  logic         done;
  logic         err;
  logic         busy;
  logic         carry_out;
  logic [4:0]   offset_out;

  int total = 0;
  int bad   = 0;

  localparam logic [207:0] C_ROTOR_I  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] C_IDENTITY = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  localparam logic [207:0] C_ALL_A    = {26{8'h41}};

  enigma_rotor #(.NOTCH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .set        (set),
    .idx_in     (idx_in),
    .offset_in  (offset_in),
    .valid      (valid),
    .din        (din),
    .dec        (dec),
    .step       (step),
    .dout       (dout),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .carry_out  (carry_out),
    .offset_out (offset_out)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_set(input logic [207:0] tbl, input logic [4:0] off);
    @(negedge clk);
    set = 1'b1; idx_in = tbl; offset_in = off;
    @(negedge clk);
    set = 1'b0;
  endtask

  // Issues one request; lat = edges after the accept edge until done (-1 = timeout).
  task automatic do_req(input logic [7:0] c, input logic dc, input logic st,
                        input bit inject, output int lat, output logic [7:0] r,
                        output logic e, output logic cy0, output logic cy1,
                        output bit busy_all);
    lat = -1; busy_all = 1'b1; cy1 = 1'b0;
    @(negedge clk);
    din = c; dec = dc; step = st; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; step = 1'b0;
    cy0 = carry_out;
    if (done) lat = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (!busy) busy_all = 1'b0;
      if (inject && k == 3) begin
        valid = 1'b1; din = "A"; dec = 1'b0; step = 1'b1;
      end
      @(negedge clk);
      valid = 1'b0; step = 1'b0;
      if (k == 1) cy1 = carry_out;
      if (done) lat = k;
    end
    r = dout; e = err;
  endtask

  int         lat;
  logic [7:0] r;
  logic       e, cy0, cy1;
  bit         ba;

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    total++; if ({done, err, carry_out, busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {done, err, carry_out, busy}); end
    total++; if (offset_out !== 5'd0) begin bad++; $display("FAIL reset_offset: got %0d want 0", offset_out); end
    reset_n = 1'b1;
    do_req("C", 1'b0, 1'b0, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== "C") begin bad++; $display("FAIL ident_fwd: got %h want %h", r, 8'h43); end
    total++; if (lat !== 1) begin bad++; $display("FAIL ident_lat: got %0d want 1", lat); end
    total++; if (offset_out !== 5'd0) begin bad++; $display("FAIL ident_offset: got %0d want 0", offset_out); end
  endtask

  task automatic test_forward();
    do_set(C_ROTOR_I, 5'd0);
    do_req("A", 1'b0, 1'b0, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== "E" || e !== 1'b0) begin bad++; $display("FAIL fwd_A: got %h err %b want 45 err 0", r, e); end
    do_req("A", 1'b0, 1'b1, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== "J") begin bad++; $display("FAIL fwd_step_A: got %h want 4a", r); end
    total++; if (offset_out !== 5'd1) begin bad++; $display("FAIL fwd_step_offset: got %0d want 1", offset_out); end
    total++; if (cy0 !== 1'b0) begin bad++; $display("FAIL fwd_step_carry: got %b want 0", cy0); end
  endtask

  task automatic test_backward();
    do_set(C_ROTOR_I, 5'd0);
    do_req("E", 1'b1, 1'b0, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== "A" || lat !== 1) begin bad++; $display("FAIL bwd_E: got %h lat %0d want 41 lat 1", r, lat); end
    do_req("J", 1'b1, 1'b1, 1'b1, lat, r, e, cy0, cy1, ba);
    total++; if (r !== "Z" || e !== 1'b0) begin bad++; $display("FAIL bwd_J: got %h err %b want 5a err 0", r, e); end
    total++; if (lat !== 26) begin bad++; $display("FAIL bwd_J_lat: got %0d want 26", lat); end
    total++; if (ba !== 1'b1) begin bad++; $display("FAIL bwd_busy: got %b want 1", ba); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL bwd_ignored_valid: got done %b want 0 (cycle %0d)", done, k); end
    end
    total++; if (offset_out !== 5'd0) begin bad++; $display("FAIL bwd_no_step: got %0d want 0", offset_out); end
    total++; if (dout !== "Z") begin bad++; $display("FAIL bwd_dout_hold: got %h want 5a", dout); end
  endtask

  task automatic test_notch();
    do_set(C_ROTOR_I, 5'd16);
    do_req("A", 1'b0, 1'b1, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (cy0 !== 1'b1 || cy1 !== 1'b0) begin bad++; $display("FAIL notch_carry: got %b%b want 10", cy0, cy1); end
    total++; if (offset_out !== 5'd17) begin bad++; $display("FAIL notch_offset: got %0d want 17", offset_out); end
    total++; if (r !== "D") begin bad++; $display("FAIL notch_fwd: got %h want 44", r); end
    do_set(C_ROTOR_I, 5'd25);
    do_req("A", 1'b0, 1'b1, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (offset_out !== 5'd0) begin bad++; $display("FAIL wrap_offset: got %0d want 0", offset_out); end
    total++; if (cy0 !== 1'b0) begin bad++; $display("FAIL wrap_carry: got %b want 0", cy0); end
    total++; if (r !== "E") begin bad++; $display("FAIL wrap_fwd: got %h want 45", r); end
    do_set(C_ROTOR_I, 5'd30);
    total++; if (offset_out !== 5'd0) begin bad++; $display("FAIL offset_clamp: got %0d want 0", offset_out); end
  endtask

  task automatic test_errors();
    do_set(C_ROTOR_I, 5'd3);
    do_req("@", 1'b0, 1'b1, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== 8'h3F || e !== 1'b1 || lat !== 0) begin bad++; $display("FAIL bad_din: got %h err %b lat %0d want 3f err 1 lat 0", r, e, lat); end
    total++; if (offset_out !== 5'd3) begin bad++; $display("FAIL bad_din_offset: got %0d want 3", offset_out); end
    @(negedge clk);
    total++; if (err !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL err_pulse: got done %b err %b want 00", done, err); end
    do_set(C_ALL_A, 5'd0);
    do_req("B", 1'b1, 1'b0, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== 8'h3F || e !== 1'b1 || lat !== 26) begin bad++; $display("FAIL no_inverse: got %h err %b lat %0d want 3f err 1 lat 26", r, e, lat); end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    do_set(C_ROTOR_I, 5'd5);
    @(negedge clk);
    din = "J"; dec = 1'b1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midscan_reset: got busy %b done %b want 00", busy, done); end
    total++; if (offset_out !== 5'd0) begin bad++; $display("FAIL midscan_offset: got %0d want 0", offset_out); end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midscan_no_done: got %b want 0", seen); end
    do_req("G", 1'b0, 1'b0, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== "G") begin bad++; $display("FAIL midscan_identity: got %h want 47", r); end
  endtask

  task automatic test_set_and_valid();
    bit seen;
    @(negedge clk);
    set = 1'b1; idx_in = C_ROTOR_I; offset_in = 5'd0;
    valid = 1'b1; din = "B"; dec = 1'b0; step = 1'b1;
    @(negedge clk);
    set = 1'b0; valid = 1'b0; step = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL setvalid_no_txn: got %b want 0", seen); end
    total++; if (offset_out !== 5'd0) begin bad++; $display("FAIL setvalid_offset: got %0d want 0", offset_out); end
    do_req("B", 1'b0, 1'b0, 1'b0, lat, r, e, cy0, cy1, ba);
    total++; if (r !== "K") begin bad++; $display("FAIL setvalid_loaded: got %h want 4b", r); end
  endtask

  initial begin
    reset_n = 1'b0; set = 1'b0; idx_in = C_IDENTITY; offset_in = 5'd0;
    valid = 1'b0; din = 8'h00; dec = 1'b0; step = 1'b0;
    test_reset();
    test_forward();
    test_backward();
    test_notch();
    test_errors();
    test_reset_mid_scan();
    test_set_and_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
